// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC job sequencer.
package mac_seq_pkg;

    localparam int ACC_W = 56;
    localparam int ACT_W = 8;

    localparam logic [1:0] PREC_FULL = 2'b00;
    localparam logic [1:0] PREC_W4   = 2'b01;
    localparam logic [1:0] PREC_W2   = 2'b10;
    localparam logic [1:0] PREC_BAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_CAPTURE
    } state_e;

endpackage

// File: rtl/mac_sequencer_if.sv
// Operand-memory read port and MAC drive/return signals of one sequencer.
// Read port: rd_en is a one-cycle strobe, rd_act/rd_wt are valid exactly one cycle later; there is no stall.
interface mac_sequencer_if #(
    parameter int ADDR_W = 10
);
    import mac_seq_pkg::*;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ACT_W-1:0]  rd_act;
    logic [ACT_W-1:0]  rd_wt;
    logic [ACT_W-1:0]  mac_act;
    logic [ACT_W-1:0]  mac_wt;
    logic [1:0]        mac_prec;
    logic              mac_en;
    logic              mac_clr_n;
    logic [ACC_W-1:0]  mac_result;

    modport master (
        output rd_en, rd_addr, mac_act, mac_wt, mac_prec, mac_en, mac_clr_n,
        input  rd_act, rd_wt, mac_result
    );

    modport slave (
        input  rd_en, rd_addr, mac_act, mac_wt, mac_prec, mac_en, mac_clr_n,
        output rd_act, rd_wt, mac_result
    );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// Operand address walker: loads base/len, steps once per read, flags the last read.
module mac_seq_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              cnt_zero,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load) begin
            addr_d = base;
            cnt_d  = len;
        end else if (step) begin
            // Address wraps naturally at 2^ADDR_W.
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr     = addr_q;
    assign cnt_zero = (cnt_q == '0);
    assign last     = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/mac_sequencer.sv
// Job controller for one MAC: clear, stream operands, drain, capture result.
// Optional performance counters (job_cnt, busy_cnt) under MAC_SEQ_PERFCNT_EN.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        prec,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ACC_W-1:0]  result,
    output state_e            dbg_state,
`ifdef MAC_SEQ_PERFCNT_EN
    output logic [15:0]       job_cnt,
    output logic [31:0]       busy_cnt,
`endif
    mac_sequencer_if.master   mem_mac
);

    state_e           state_q, state_d;
    logic             drain_q, drain_d;
    logic [1:0]       prec_q, prec_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clr_n_q, clr_n_d;
    logic             rd_en_q, rd_en_d;
    logic             load;
    logic             abort_hit;
    logic             flush;
    logic             cnt_zero;
    logic             last_rd;

    mac_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .step     (rd_en_d),
        .base     (base),
        .len      (len),
        .addr     (mem_mac.rd_addr),
        .cnt_zero (cnt_zero),
        .last     (last_rd)
    );

    assign abort_hit = abort && (state_q != ST_IDLE);
    // Second drain cycle: enable with zero operands pushes the product register into Result.
    assign flush     = (state_q == ST_DRAIN) && drain_q;

    always_comb begin
        state_d  = state_q;
        drain_d  = 1'b0;
        prec_d   = prec_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rd_en_d  = 1'b0;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (prec == PREC_BAD) begin
                        err_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        prec_d  = prec;
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR:   state_d = cnt_zero ? ST_CAPTURE : ST_RUN;
            ST_RUN: begin
                rd_en_d = 1'b1;
                if (last_rd) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                result_d = mem_mac.mac_result;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
        // Abort wins over everything, including the capture edge.
        if (abort_hit) begin
            state_d  = ST_IDLE;
            drain_d  = 1'b0;
            rd_en_d  = 1'b0;
            result_d = result_q;
            done_d   = 1'b0;
        end
        clr_n_d = (state_d != ST_CLEAR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            drain_q  <= 1'b0;
            prec_q   <= PREC_FULL;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            clr_n_q  <= 1'b1;
            rd_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            prec_q   <= prec_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
            clr_n_q  <= clr_n_d;
            rd_en_q  <= rd_en_d;
        end
    end

    assign mem_mac.rd_en     = rd_en_d;
    assign mem_mac.mac_en    = !abort_hit && (rd_en_q || flush);
    assign mem_mac.mac_act   = rd_en_q ? mem_mac.rd_act : '0;
    assign mem_mac.mac_wt    = rd_en_q ? mem_mac.rd_wt  : '0;
    assign mem_mac.mac_prec  = prec_q;
    assign mem_mac.mac_clr_n = clr_n_q;

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;
    assign dbg_state = state_q;

`ifdef MAC_SEQ_PERFCNT_EN
    logic [15:0] job_cnt_q, job_cnt_d;
    logic [31:0] busy_cnt_q, busy_cnt_d;

    always_comb begin
        job_cnt_d  = job_cnt_q + 16'(done_q);
        busy_cnt_d = busy_cnt_q + 32'(busy);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            job_cnt_q  <= '0;
            busy_cnt_q <= '0;
        end else begin
            job_cnt_q  <= job_cnt_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign job_cnt  = job_cnt_q;
    assign busy_cnt = busy_cnt_q;
`endif

endmodule
